// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with a double-buffered digit bank.
// Define SEG7_SCAN_BLINK_EN to build the per-digit blink counter and phase.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 131072,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   enables,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    pending,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              segment,
  output logic                    dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [5*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   blink;
  } bank_t;

  localparam bank_t BANK_RST = '{digits: {NUM_DIGITS{5'h1F}}, dp: '0, en: '0, blink: '0};

  // Active-low cathodes, bit 6 = A down to bit 0 = G.
  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'h00: decode = 7'b0000001;
      5'h01: decode = 7'b1001111;
      5'h02: decode = 7'b0010010;
      5'h03: decode = 7'b0000110;
      5'h04: decode = 7'b1001100;
      5'h05: decode = 7'b0100100;
      5'h06: decode = 7'b0100000;
      5'h07: decode = 7'b0001111;
      5'h08: decode = 7'b0000000;
      5'h09: decode = 7'b0000100;
      5'h0A: decode = 7'b0001000;
      5'h0B: decode = 7'b1100000;
      5'h0C: decode = 7'b0110001;
      5'h0D: decode = 7'b1000010;
      5'h0E: decode = 7'b0110000;
      5'h0F: decode = 7'b0111000;
      5'h10: decode = 7'b0100001;
      5'h11: decode = 7'b1001000;
      5'h12: decode = 7'b1111110;
      default: decode = 7'b1111111;
    endcase
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  tick_q, tick_d;
  bank_t                 pend_q, pend_d, act_q, act_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  presc_last, boundary, blink_phase;
  logic [NUM_DIGITS-1:0] blink_off;
  logic [4:0]            code;

  assign presc_last = (presc_q == PRESC_LAST);
  assign boundary   = presc_last && (idx_q == IDX_LAST);

`ifdef SEG7_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_phase = blink_phase_q;
`else
  assign blink_phase = 1'b0;
`endif

  assign blink_off = act_q.blink & {NUM_DIGITS{blink_phase}};
  assign code      = act_q.digits[5*int'(idx_q) +: 5];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    presc_d   = presc_last ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    pend_d    = pend_q;
    act_d     = act_q;
    pending_d = pending_q;
    tick_d    = boundary;
    an_d      = '1;

    if (presc_last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    // Commit reads the old pending bank, so a load on the boundary lands one frame later.
    if (boundary && pending_q) begin
      act_d     = pend_q;
      pending_d = 1'b0;
    end
    if (load) begin
      pend_d    = '{digits: digits_in, dp: dp_in, en: enables, blink: blink_mask};
      pending_d = 1'b1;
    end

    if (act_q.en[idx_q] && !blink_off[idx_q]) an_d[idx_q] = 1'b0;
    seg_d = decode(code);
    dp_d  = ~act_q.dp[idx_q];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= BANK_RST;
      act_q     <= BANK_RST;
      an_q      <= '1;
      seg_q     <= 7'b1111111;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      act_q     <= act_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = tick_q;
  assign an         = an_q;
  assign segment    = seg_q;
  assign dp         = dp_q;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller for the Basys3 front panel and wider boards. It time-multiplexes `NUM_DIGITS` common-anode digits from a double-buffered digit bank. New display contents are committed only at frame boundaries, so the display never tears. It also supports per-digit decimal points, per-digit enables and an optional per-digit blink mode, and sits between the communication/crypto status logic and the board pins.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of multiplexed digits, range 2..8.
- `SCAN_DIV`, default 131072: clock cycles each digit stays lit, must be ≥2.
- `BLINK_FRAMES`, default 64: full scan frames per blink half-period, must be ≥1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: single-cycle strobe that captures `digits_in`, `dp_in`, `enables` and `blink_mask` into the pending buffer.
- `digits_in` in 5*NUM_DIGITS: digit codes, 5 bits each; digit 0 is in bits [4:0] and is the rightmost digit.
- `dp_in` in NUM_DIGITS: decimal point per digit, 1 = lit.
- `enables` in NUM_DIGITS: digit enable, 1 = digit may light.
- `blink_mask` in NUM_DIGITS: 1 = digit blinks.
- `pending` out 1: a load is captured but not yet committed.
- `frame_tick` out 1: one-cycle pulse on the cycle the scan index wraps to 0.
- `an` out NUM_DIGITS: anode selects, active low.
- `segment` out 7: cathodes in order {A,B,C,D,E,F,G}, active low.
- `dp` out 1: decimal-point cathode, active low.

## Operation
- The prescaler counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the scan index advances.
- The scan index counts 0..NUM_DIGITS-1 and wraps to 0. The wrap cycle is the frame boundary.
- Double buffering:
  - `load` writes the pending buffer and sets `pending`.
  - At each frame boundary, if `pending` is set, the pending buffer is copied to the active buffer and `pending` clears.
  - Display logic reads only the active buffer.
- Digit decode:
  - 0x00–0x0F: hex 0–F.
  - 0x10: G. 0x11: H. 0x12: '-' (`segment`=1111110).
  - 0x1F and all other codes: blank (`segment`=1111111).
  - Required encodings: 0 = 0000001, 8 = 0000000, E = 0110000, F = 0111000.
- A digit whose enable bit is 0 keeps its `an` bit at 1 for the whole time slot; `segment` and `dp` are don't-care during that slot.
- `dp` = ~dp_active[index].

## Timing
- Reset values: prescaler 0, index 0, blink counter 0, blink phase 0, `pending` 0, `frame_tick` 0.
- Reset values, continued: active and pending buffers = all digits 0x1F, dp 0, enables 0, blink_mask 0. `an` all 1, `segment` 1111111, `dp` 1.
- Outputs `an`, `segment` and `dp` are registered. They reflect a new index one cycle after the index register changes.
- `frame_tick` is registered. It asserts on the cycle the index register becomes 0 through a wrap, not through reset.
- Commit happens on the same clock edge as the index wrap. The first slot of the new frame already shows committed data.
- `load` on the frame-boundary cycle:
  - The pending buffer is written with the new data and `pending` stays 1.
  - The old pending contents are committed on that edge.
  - The new data commits at the next boundary.
- `load` while `pending`=1: newest data overwrites the pending buffer. There is one commit per boundary and no queueing.
- `rst` mid-frame: on the next edge every register takes its reset value, regardless of `load`.
- Worst-case latency from `load` to display is NUM_DIGITS*SCAN_DIV+1 cycles.

## Configuration
- Macro `SEG7_SCAN_BLINK_EN`.
- Defined:
  - A blink counter counts frame boundaries 0..BLINK_FRAMES-1. At terminal count it wraps and toggles the blink phase.
  - While the phase is 1, digits with active blink_mask=1 hold `an` at 1.
  - Blink counter and phase reset to 0.
- Undefined:
  - No blink counter or phase register is built.
  - `blink_mask` is captured into the buffers but ignored.
  - Display is identical to the phase=0 case.

## Test plan
- Reset, then hold idle with NUM_DIGITS=4, SCAN_DIV=4 → `an`=1111 every cycle, `segment`=1111111, `dp`=1; `frame_tick` pulses every 16 cycles.
- Load digits {3,2,1,0}=0x0E,0x08,0x1F,0x00 with enables=1111 and dp_in=0001 → from the next frame boundary:
  - `an` sequence 1110,1101,1011,0111, each held 4 cycles.
  - Digit 0: `segment`=0000001 with `dp`=0.
  - Digit 1: `segment`=1111111.
  - Digit 2: 0000000.
  - Digit 3: 0110000.
- Issue two `load`s mid-frame with digit0=0x01 then 0x02 → `pending`=1 until the boundary; digit 0 shows 2 (0010010) and never shows 1.
- Issue `load` exactly on the boundary cycle → the previously pending data displays this frame, the new data next frame, and `pending` is 1 for NUM_DIGITS*SCAN_DIV cycles.
- Set enables=0101 → `an` bits 1 and 3 stay 1 in all slots.
- With SEG7_SCAN_BLINK_EN, BLINK_FRAMES=2 and blink_mask=0001 → digit 0 is lit for frames 0–1, dark for frames 2–3, lit again for 4–5. Without the macro, digit 0 is always lit.
